cdc_sync_filter: RTL and testbench

Multi-channel, single-clock input conditioner and next-generation replacement for the plain multi-flop synchronizer. Each of CHANNELS asynchronous inputs passes through a STAGES-deep flop chain and then a per-channel stability (deglitch) filter. The block produces a clean level plus one-cycle rise, fall and change pulses. It sits at the boundary between asynchronous pins or foreign-domain level/toggle signals and the local clk domain.

---
 rtl/cdc_sync_filter.sv | 137 +++++++++++++
 tb/tb_cdc_sync_filter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_sync_filter.sv
// -----------------------------------------------------------------------------
// cdc_sync_filter
//   Multi-channel input conditioner for asynchronous pins and foreign-domain
//   level or toggle signals. Each channel has three parts:
//     - a STAGES-deep synchronizer flop chain,
//     - a per-channel stability filter,
//     - registered one-cycle rise, fall and change pulses.
//   Channels are independent of each other, so multi-bit buses must not be
//   passed through this block.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   async_in   : [CHANNELS] asynchronous inputs
//   level_out  : [CHANNELS] filtered, synchronized level (registered)
//   rise_o     : [CHANNELS] one-cycle pulse when level_out goes 0->1
//   fall_o     : [CHANNELS] one-cycle pulse when level_out goes 1->0
//   change_o   : [CHANNELS] rise_o | fall_o (registered)
// -----------------------------------------------------------------------------
module cdc_sync_filter #(
   parameter int unsigned         CHANNELS    = 8,
   parameter int unsigned         STAGES      = 2,
   parameter int unsigned         FILTER_LEN  = 4,
   parameter logic [CHANNELS-1:0] RESET_VAL   = '0,
   parameter logic [CHANNELS-1:0] TOGGLE_MASK = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] async_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] rise_o,
   output logic [CHANNELS-1:0] fall_o,
   output logic [CHANNELS-1:0] change_o
);

   // Parameter sanity checks, evaluated at elaboration.
   if (CHANNELS < 1) begin : g_chk_channels
      $error("cdc_sync_filter: CHANNELS must be >= 1");
   end
   if (STAGES < 2) begin : g_chk_stages
      $error("cdc_sync_filter: STAGES must be >= 2");
   end
   if (FILTER_LEN < 1) begin : g_chk_filter
      $error("cdc_sync_filter: FILTER_LEN must be >= 1");
   end

   localparam int unsigned       CNT_W   = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

   // Synchronizer chain: only stage 0 may go metastable, so no logic is
   // allowed between stages.
   logic [CHANNELS-1:0] sync_q [STAGES];
   logic [CHANNELS-1:0] sv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            sync_q[k] <= RESET_VAL;
         end
      end else begin
         sync_q[0] <= async_in;
         for (int k = 1; k < STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sv = sync_q[STAGES-1];

   // Per-channel filter. upd_d[i] means level_out[i] takes sv[i] on this edge.
   logic [CHANNELS-1:0] level_q;
   logic [CHANNELS-1:0] rise_q;
   logic [CHANNELS-1:0] fall_q;
   logic [CHANNELS-1:0] change_q;
   logic [CHANNELS-1:0] upd_d;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         if (TOGGLE_MASK[gi]) begin : g_toggle
            // Toggle mode: the filter is bypassed, so every sv transition is passed on.
            assign upd_d[gi] = (sv[gi] != level_q[gi]);
         end else begin : g_filter
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             upd;

            // cnt counts consecutive cycles in which sv disagrees with the
            // current level. It clears on any agreement, so a short glitch
            // leaves no trace. The maximum count is CNT_MAX, so it never wraps.
            always_comb begin
               cnt_d = '0;
               upd   = 1'b0;
               if (sv[gi] != level_q[gi]) begin
                  if (cnt_q == CNT_MAX) begin
                     upd = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            assign upd_d[gi] = upd;
         end
      end
   endgenerate

   // The level and its pulses share one register stage, so each pulse is
   // high on the same edge that changes level_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q  <= RESET_VAL;
         rise_q   <= '0;
         fall_q   <= '0;
         change_q <= '0;
      end else begin
         level_q  <= (level_q & ~upd_d) | (sv & upd_d);
         rise_q   <= upd_d & sv;
         fall_q   <= upd_d & ~sv;
         change_q <= upd_d;
      end
   end

   assign level_out = level_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign change_o  = change_q;

endmodule

// File: tb/tb_cdc_sync_filter.sv
// -----------------------------------------------------------------------------
// tb_cdc_sync_filter
//   Drives two instances of cdc_sync_filter from the same stimulus:
//     dut_a : STAGES 2, FILTER_LEN 4, RESET_VAL 00, TOGGLE_MASK 04
//     dut_b : STAGES 3, FILTER_LEN 1, RESET_VAL FF, TOGGLE_MASK 00
//   The reference model keeps a history of the value captured at every edge.
//   A channel's level moves to v when the last N synchronized samples all
//   equal v and v differs from the current level. N is FILTER_LEN for a
//   filtered channel and 1 for a toggle channel.
// -----------------------------------------------------------------------------
module tb_cdc_sync_filter;

   localparam int          CH   = 8;
   localparam int          A_ST = 2;
   localparam int          A_FL = 4;
   localparam logic [7:0]  A_RV = 8'h00;
   localparam logic [7:0]  A_TM = 8'h04;
   localparam int          B_ST = 3;
   localparam int          B_FL = 1;
   localparam logic [7:0]  B_RV = 8'hFF;
   localparam logic [7:0]  B_TM = 8'h00;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] async_in;
   logic [7:0] lvl_a, rise_a, fall_a, chg_a;
   logic [7:0] lvl_b, rise_b, fall_b, chg_b;

   always #5 clk = ~clk;

   cdc_sync_filter #(
      .CHANNELS(CH), .STAGES(A_ST), .FILTER_LEN(A_FL),
      .RESET_VAL(A_RV), .TOGGLE_MASK(A_TM)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .async_in(async_in),
      .level_out(lvl_a), .rise_o(rise_a), .fall_o(fall_a), .change_o(chg_a)
   );

   cdc_sync_filter #(
      .CHANNELS(CH), .STAGES(B_ST), .FILTER_LEN(B_FL),
      .RESET_VAL(B_RV), .TOGGLE_MASK(B_TM)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .async_in(async_in),
      .level_out(lvl_b), .rise_o(rise_b), .fall_o(fall_b), .change_o(chg_b)
   );

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] cap_q[$];   // cap_q[e-1] = async_in captured at edge e after reset
   int         edge_n;
   logic [7:0] m_lvl_a, m_rise_a, m_fall_a;
   logic [7:0] m_lvl_b, m_rise_b, m_fall_b;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // Synchronizer output just before edge e. It holds the value captured
   // STAGES edges earlier, or the reset value before any capture exists.
   function automatic logic [7:0] sv_pre(input int e, input int st, input logic [7:0] rv);
      int idx;
      idx = e - st;
      if (idx >= 1) return cap_q[idx-1];
      return rv;
   endfunction

   task automatic model_edge(input int st, input int fl, input logic [7:0] tm,
                             input logic [7:0] rv, inout logic [7:0] lvl,
                             output logic [7:0] rise, output logic [7:0] fall);
      logic [7:0] now_v, past_v;
      int         win;
      bit         stable;
      rise  = '0;
      fall  = '0;
      now_v = sv_pre(edge_n, st, rv);
      for (int c = 0; c < CH; c++) begin
         win    = tm[c] ? 1 : fl;
         stable = 1'b1;
         for (int j = 0; j < win; j++) begin
            past_v = sv_pre(edge_n - j, st, rv);
            if (past_v[c] != now_v[c]) stable = 1'b0;
         end
         if (stable && (now_v[c] != lvl[c])) begin
            lvl[c]  = now_v[c];
            rise[c] = now_v[c];
            fall[c] = ~now_v[c];
         end
      end
   endtask

   task automatic compare_all();
      check_eq("lvl_a",  lvl_a,  m_lvl_a);
      check_eq("rise_a", rise_a, m_rise_a);
      check_eq("fall_a", fall_a, m_fall_a);
      check_eq("chg_a",  chg_a,  m_rise_a | m_fall_a);
      check_eq("lvl_b",  lvl_b,  m_lvl_b);
      check_eq("rise_b", rise_b, m_rise_b);
      check_eq("fall_b", fall_b, m_fall_b);
      check_eq("chg_b",  chg_b,  m_rise_b | m_fall_b);
   endtask

   // One clock cycle. The task is entered at a negedge and returns at the
   // next negedge, after the outputs of that edge have been compared.
   task automatic cycle(input logic [7:0] val);
      async_in = val;
      @(posedge clk);
      if (rst_n) begin
         cap_q.push_back(val);
         edge_n++;
         model_edge(A_ST, A_FL, A_TM, A_RV, m_lvl_a, m_rise_a, m_fall_a);
         model_edge(B_ST, B_FL, B_TM, B_RV, m_lvl_b, m_rise_b, m_fall_b);
      end
      @(negedge clk);
      compare_all();
      $display("edge %0d in=%h | a: lvl=%h r=%h f=%h c=%h | b: lvl=%h r=%h f=%h c=%h",
               edge_n, val, lvl_a, rise_a, fall_a, chg_a, lvl_b, rise_b, fall_b, chg_b);
   endtask

   // Asserts reset away from the clock edge, checks that it takes effect
   // without waiting for an edge, then releases it at a later negedge.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      cap_q.delete();
      edge_n   = 0;
      m_lvl_a  = A_RV; m_rise_a = '0; m_fall_a = '0;
      m_lvl_b  = B_RV; m_rise_b = '0; m_fall_b = '0;
      compare_all();
      $display("reset asserted: a.lvl=%h b.lvl=%h", lvl_a, lvl_b);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int         lat, cap, cnt, rcnt, fcnt, r_edge, f_edge;
      logic [7:0] val, flip;

      rst_n    = 1'b1;
      async_in = 8'h00;
      edge_n   = 0;
      @(negedge clk);

      // Reset, then hold 0 (dut_a's reset value). dut_b sees a step from
      // FF to 0 on its first capture edge.
      apply_reset();
      check_eq("rst_lvl_b", lvl_b, 8'hFF);
      lat = -1; cnt = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(8'h00);
         cnt += ((rise_a | fall_a | chg_a) != 8'h00) ? 1 : 0;
         if (fall_b[0] && lat < 0) lat = edge_n - 1;
      end
      check_eq("idle_pulses_a", cnt, 0);
      check_eq("lat_fall_b", lat, 3);

      // ch0 steps 0->1 and then 1->0 on dut_a.
      cycle(8'h01); cap = edge_n; lat = -1;
      for (int k = 0; k < 10; k++) begin
         if (lat < 0 && rise_a[0]) lat = edge_n - cap;
         cycle(8'h01);
      end
      check_eq("lat_rise_a0", lat, 5);
      cycle(8'h00); cap = edge_n; lat = -1;
      for (int k = 0; k < 10; k++) begin
         if (lat < 0 && fall_a[0]) lat = edge_n - cap;
         cycle(8'h00);
      end
      check_eq("lat_fall_a0", lat, 5);

      // ch1: a 3-cycle glitch is filtered out; a 4-cycle pulse gets through.
      cnt = 0;
      for (int k = 0; k < 15; k++) begin
         cycle((k < 3) ? 8'h02 : 8'h00);
         cnt += (rise_a[1] | fall_a[1]) ? 1 : 0;
      end
      check_eq("glitch3_pulses", cnt, 0);
      rcnt = 0; fcnt = 0; r_edge = -100; f_edge = 0;
      for (int k = 0; k < 15; k++) begin
         cycle((k < 4) ? 8'h02 : 8'h00);
         if (rise_a[1]) begin rcnt++; r_edge = edge_n; end
         if (fall_a[1]) begin fcnt++; f_edge = edge_n; end
      end
      check_eq("pulse4_rise", rcnt, 1);
      check_eq("pulse4_fall", fcnt, 1);
      check_eq("pulse4_gap", f_edge - r_edge, 4);

      // ch2 is in toggle mode: 10 toggles, one every 3 cycles.
      val = 8'h00; cnt = 0; lat = -1;
      for (int t = 0; t < 10; t++) begin
         val ^= 8'h04;
         for (int k = 0; k < 3; k++) begin
            cycle(val);
            if (t == 0 && k == 0) cap = edge_n;
            if (lat < 0 && chg_a[2]) lat = edge_n - cap;
            cnt += chg_a[2] ? 1 : 0;
         end
      end
      for (int k = 0; k < 6; k++) begin
         cycle(val);
         cnt += chg_a[2] ? 1 : 0;
      end
      check_eq("toggle_count", cnt, 10);
      check_eq("toggle_lat", lat, 2);

      // All channels stepped on different cycles; ch0 and ch6 share a cycle.
      val = 8'h00;
      cycle(val);
      for (int k = 0; k < 7; k++) begin
         case (k)
            0: val[7] = 1'b1;
            1: val[3] = 1'b1;
            2: val[5] = 1'b1;
            3: begin val[0] = 1'b1; val[6] = 1'b1; end
            4: val[1] = 1'b1;
            5: val[4] = 1'b1;
            default: val[2] = ~val[2];
         endcase
         cycle(val);
      end
      for (int k = 0; k < 10; k++) cycle(val);

      // Random activity: each bit flips with probability 1/5 per cycle.
      for (int k = 0; k < 400; k++) begin
         flip = '0;
         for (int c = 0; c < CH; c++) flip[c] = ($urandom_range(0, 4) == 0);
         val ^= flip;
         cycle(val);
      end

      // Settle on a known pattern, begin a change, then reset in mid-count.
      for (int k = 0; k < 12; k++) cycle(8'h0F);
      check_eq("pre_rst_lvl_a", lvl_a, 8'h0F);
      for (int k = 0; k < 2; k++) cycle(8'hF0);
      apply_reset();
      for (int k = 0; k < 20; k++) cycle(8'h00);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Watchdog: the bench is expected to finish well before this time.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
